// File: rtl/bg_pkg.sv
// Shared types, widths and the per-channel brightness scaler for the background fade pipeline.
package bg_pkg;

    localparam int unsigned CH_W   = 8;
    localparam int unsigned LVL_W  = 5;
    localparam int unsigned STAT_W = 4;
    localparam int unsigned PROD_W = 13;

    localparam logic [LVL_W-1:0] FADE_LEVEL_MAX = LVL_W'(16);

    typedef enum logic [1:0] {
        DARK     = 2'd0,
        FADE_IN  = 2'd1,
        SHOWN    = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_t;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb24_t;

    // (c * level) >> 4; level 16 reproduces c exactly, level 0 gives black
    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                                 input logic [LVL_W-1:0] lvl);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(c) * PROD_W'(lvl);
        return CH_W'(prod >> 4);
    endfunction

    function automatic rgb24_t scale_rgb(input rgb24_t c, input logic [LVL_W-1:0] lvl);
        rgb24_t o;
        o.r = scale_ch(c.r, lvl);
        o.g = scale_ch(c.g, lvl);
        o.b = scale_ch(c.b, lvl);
        return o;
    endfunction

endpackage

// File: rtl/frame_strobe.sv
// Counts falling edges of vsync and emits a one-cycle tick every FADE_STEP_FRAMES frames.
module frame_strobe #(
    parameter int unsigned FADE_STEP_FRAMES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_vs,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CNT_W = 4;

    logic             r_vs_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_fall;
    logic             w_last;

    assign w_fall = r_vs_d & ~i_vs;
    assign w_last = (r_cnt == CNT_W'(FADE_STEP_FRAMES - 1));
    assign o_tick = r_tick;

    // A state change restarts the frame count so every level holds for full steps
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vs_d <= 1'b0;
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_vs_d <= i_vs;
            r_tick <= 1'b0;
            if (i_clr) begin
                r_cnt <= '0;
            end else if (w_fall) begin
                if (w_last) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bg_fade_pipe.sv
// Two-stage VGA output pipeline that fades the background page in and out.
// Build option: define BG_FADE_EN for the frame-stepped fade FSM; otherwise the background switches hard.
module bg_fade_pipe
    import bg_pkg::*;
#(
    parameter int unsigned       FADE_STEP_FRAMES = 2,
    parameter logic [STAT_W-1:0] BG_STATUS        = 4'b0001
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [STAT_W-1:0] status,
    input  logic              is_background,
    input  logic [23:0]       bg_color,
    input  logic [23:0]       fg_color,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              blank_n_in,
    output logic [CH_W-1:0]   VGA_R,
    output logic [CH_W-1:0]   VGA_G,
    output logic [CH_W-1:0]   VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic [LVL_W-1:0]  fade_level,
    output logic              fade_busy
);

    if ((FADE_STEP_FRAMES < 1) || (FADE_STEP_FRAMES > 15)) begin : g_bad_step
        $error("FADE_STEP_FRAMES must be in 1..15");
    end

    logic [STAT_W-1:0] r1_status;
    logic              r1_is_bg;
    rgb24_t            r1_bg;
    rgb24_t            r1_fg;
    logic              r1_hs;
    logic              r1_vs;
    logic              r1_blank_n;

    logic [LVL_W-1:0]  r_level;
    logic              r_busy;
    logic              w_match;
    rgb24_t            w_bg_px;
    rgb24_t            w_px;

    assign w_match    = (r1_status == BG_STATUS);
    assign fade_level = r_level;
    assign fade_busy  = r_busy;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r1_status  <= '0;
            r1_is_bg   <= 1'b0;
            r1_bg      <= '0;
            r1_fg      <= '0;
            r1_hs      <= 1'b0;
            r1_vs      <= 1'b0;
            r1_blank_n <= 1'b0;
        end else begin
            r1_status  <= status;
            r1_is_bg   <= is_background;
            r1_bg      <= bg_color;
            r1_fg      <= fg_color;
            r1_hs      <= hs_in;
            r1_vs      <= vs_in;
            r1_blank_n <= blank_n_in;
        end
    end

`ifdef BG_FADE_EN
    fade_state_t      r_state;
    fade_state_t      w_state_nxt;
    logic [LVL_W-1:0] w_level_nxt;
    logic             w_tick;
    logic             w_state_chg;

    frame_strobe #(
        .FADE_STEP_FRAMES (FADE_STEP_FRAMES)
    ) u_strobe (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_vs    (r1_vs),
        .i_clr   (w_state_chg),
        .o_tick  (w_tick)
    );

    assign w_state_chg = (w_state_nxt != r_state);

    // Status decides direction first, so a coincident tick steps the new way
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        case (r_state)
            DARK:     if (w_match)  w_state_nxt = FADE_IN;
            FADE_IN:  if (!w_match) w_state_nxt = FADE_OUT;
            SHOWN:    if (!w_match) w_state_nxt = FADE_OUT;
            FADE_OUT: if (w_match)  w_state_nxt = FADE_IN;
            default:                w_state_nxt = DARK;
        endcase
        if (w_tick) begin
            if ((w_state_nxt == FADE_IN) && (r_level < FADE_LEVEL_MAX)) begin
                w_level_nxt = r_level + LVL_W'(1);
            end else if ((w_state_nxt == FADE_OUT) && (r_level != '0)) begin
                w_level_nxt = r_level - LVL_W'(1);
            end
        end
        if ((w_state_nxt == FADE_IN) && (w_level_nxt == FADE_LEVEL_MAX)) begin
            w_state_nxt = SHOWN;
        end else if ((w_state_nxt == FADE_OUT) && (w_level_nxt == '0)) begin
            w_state_nxt = DARK;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= DARK;
            r_level <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_busy  <= (w_state_nxt == FADE_IN) || (w_state_nxt == FADE_OUT);
        end
    end

    assign w_bg_px = scale_rgb(r1_bg, r_level);
`else
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_level <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_level <= w_match ? FADE_LEVEL_MAX : '0;
            r_busy  <= 1'b0;
        end
    end

    // Keyed on the stage-1 status so the pixel and its page stay aligned
    assign w_bg_px = w_match ? r1_bg : '0;
`endif

    always_comb begin
        w_px = '0;
        if (r1_blank_n) begin
            w_px = r1_is_bg ? w_bg_px : r1_fg;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
        end else begin
            VGA_R       <= w_px.r;
            VGA_G       <= w_px.g;
            VGA_B       <= w_px.b;
            VGA_HS      <= r1_hs;
            VGA_VS      <= r1_vs;
            VGA_BLANK_N <= r1_blank_n;
        end
    end

endmodule

// File: tb/tb_bg_fade_pipe.sv
// Directed-plus-random bench for bg_fade_pipe; expectations come from a frame-level fade model.
module tb_bg_fade_pipe;

    localparam int unsigned STEP = 2;
    localparam logic [3:0]  BG   = 4'b0001;

    logic        Clk;
    logic        Reset_n;
    logic [3:0]  status;
    logic        is_background;
    logic [23:0] bg_color;
    logic [23:0] fg_color;
    logic        hs_in;
    logic        vs_in;
    logic        blank_n_in;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic [4:0]  fade_level;
    logic        fade_busy;

    bg_fade_pipe #(
        .FADE_STEP_FRAMES (STEP),
        .BG_STATUS        (BG)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .status        (status),
        .is_background (is_background),
        .bg_color      (bg_color),
        .fg_color      (fg_color),
        .hs_in         (hs_in),
        .vs_in         (vs_in),
        .blank_n_in    (blank_n_in),
        .VGA_R         (VGA_R),
        .VGA_G         (VGA_G),
        .VGA_B         (VGA_B),
        .VGA_HS        (VGA_HS),
        .VGA_VS        (VGA_VS),
        .VGA_BLANK_N   (VGA_BLANK_N),
        .fade_level    (fade_level),
        .fade_busy     (fade_busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_assert = 0;
    int n_fail   = 0;
    int m_level  = 0;
    int m_cnt    = 0;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int target();
        return (status == BG) ? 16 : 0;
    endfunction

    function automatic logic [7:0] sc(input logic [7:0] c, input int lvl);
        return 8'((int'(c) * lvl) / 16);
    endfunction

    function automatic logic exp_busy();
`ifdef BG_FADE_EN
        return (m_level != target());
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_level(input string tag);
        check({tag, "_lvl"}, 32'(fade_level), 32'(m_level));
        check({tag, "_busy"}, 32'(fade_busy), 32'(exp_busy()));
    endtask

    // Any flip of page membership restarts the frame count
    task automatic set_status(input logic [3:0] s);
        logic old_match;
        old_match = (status == BG);
        status = s;
`ifdef BG_FADE_EN
        if (old_match != (s == BG)) m_cnt = 0;
`else
        m_level = target();
`endif
        repeat (4) cyc();
    endtask

    // One frame; the level moves one step toward its target every STEP frames
    task automatic frame();
        vs_in = 1'b0;
        repeat (4) cyc();
        vs_in = 1'b1;
        repeat (4) cyc();
`ifdef BG_FADE_EN
        m_cnt++;
        if (m_cnt == STEP) begin
            m_cnt = 0;
            if (m_level < target()) m_level++;
            else if (m_level > target()) m_level--;
        end
`endif
    endtask

    task automatic frames(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            frame();
            check_level($sformatf("%s_f%0d", tag, i));
        end
    endtask

    task automatic run_pix(input int n, input bit sync_rand);
        logic [26:0] q[$];
        logic [26:0] e;
        logic [23:0] px;
        for (int i = 0; i < n + 2; i++) begin
            if (i >= 2) begin
                e = q.pop_front();
                check("pix_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(e[23:0]));
                check("pix_sync", 32'({VGA_HS, VGA_VS, VGA_BLANK_N}), 32'(e[26:24]));
            end
            if (i < n) begin
                bg_color      = 24'($urandom);
                fg_color      = 24'($urandom);
                is_background = 1'($urandom);
                blank_n_in    = (($urandom % 4) != 0);
                hs_in         = 1'($urandom);
                vs_in         = sync_rand ? 1'($urandom) : 1'b1;
                if (!blank_n_in)        px = 24'h0;
                else if (is_background) px = {sc(bg_color[23:16], m_level),
                                              sc(bg_color[15:8], m_level),
                                              sc(bg_color[7:0], m_level)};
                else                    px = fg_color;
                q.push_back({hs_in, vs_in, blank_n_in, px});
            end
            cyc();
        end
        vs_in      = 1'b1;
        hs_in      = 1'b1;
        blank_n_in = 1'b1;
        repeat (3) cyc();
    endtask

    task automatic directed_bg(input logic [23:0] exp, input string tag);
        bg_color      = 24'hF80504;
        fg_color      = 24'h123456;
        is_background = 1'b1;
        blank_n_in    = 1'b1;
        repeat (2) cyc();
        check(tag, 32'({VGA_R, VGA_G, VGA_B}), 32'(exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
        check({tag, "_hs"}, 32'(VGA_HS), 32'h1);
        check({tag, "_vs"}, 32'(VGA_VS), 32'h1);
        check({tag, "_blank"}, 32'(VGA_BLANK_N), 32'h0);
        check({tag, "_lvl"}, 32'(fade_level), 32'h0);
        check({tag, "_busy"}, 32'(fade_busy), 32'h0);
    endtask

    initial begin
        Reset_n       = 1'b0;
        status        = 4'h0;
        is_background = 1'b0;
        bg_color      = 24'h0;
        fg_color      = 24'h0;
        hs_in         = 1'b1;
        vs_in         = 1'b1;
        blank_n_in    = 1'b1;
        repeat (3) cyc();
        check_reset_outputs("rst");
        @(posedge Clk);
        #2 Reset_n = 1'b1;
        repeat (4) cyc();
        check_level("idle");

        // Fade in: one level per two frames, SHOWN after 32 frames
        set_status(BG);
        frames(32, "fin");
        run_pix(40, 1'b0);
        directed_bg(24'hF80504, "bg_l16");

        // Fade out to level 8
        set_status(4'h3);
        frames(16, "fout");
        run_pix(40, 1'b0);
`ifdef BG_FADE_EN
        directed_bg(24'h7C0202, "bg_l8");
`else
        directed_bg(24'h000000, "bg_off");
`endif

        // Back up to 10, then leave the page: level 9 after the next tick, dark after 20 frames
        set_status(BG);
        frames(4, "fin2");
        set_status(4'h2);
        frames(20, "fout2");

        run_pix(60, 1'b1);

        // Asynchronous reset in the middle of a fade
        set_status(BG);
        frames(6, "fin3");
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        status  = 4'h0;
        m_level = 0;
        m_cnt   = 0;
        repeat (2) cyc();
        @(posedge Clk);
        #2 Reset_n = 1'b1;
        repeat (4) cyc();
        check_level("post_rst");
        frames(2, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bg_fade_pipe.md
BG_FADE_PIPE -- requirements
Module: bg_fade_pipe

Interface
REQ-001 Parameter FADE_STEP_FRAMES, default 2, sets the number of frames per fade level step (legal range 1..15).
REQ-002 Parameter BG_STATUS, default 4'b0001, is the status code of the background page.
REQ-003 Port Clk, input, 1: the single clock, pixel clock domain.
REQ-004 Port Reset_n, input, 1: asynchronous active-low reset.
REQ-005 Port status, input, 4: current game page code.
REQ-006 Port is_background, input, 1: pixel belongs to the background, aligned with bg_color.
REQ-007 Port bg_color, input, 24: background ROM colour {R,G,B}.
REQ-008 Port fg_color, input, 24: colour for non-background pixels, unscaled.
REQ-009 Port hs_in, vs_in, blank_n_in, input, 1 each: sync and blank, aligned with the colour inputs.
REQ-010 Port VGA_R, VGA_G, VGA_B, output, 8 each: final pixel colour.
REQ-011 Port VGA_HS, VGA_VS, VGA_BLANK_N, output, 1 each: sync and blank, delayed to match the colour outputs.
REQ-012 Port fade_level, output, 5: current brightness, 0..16.
REQ-013 Port fade_busy, output, 1: high in FADE_IN or FADE_OUT.

Function
REQ-014 Pipeline SHALL be 2 stages: stage 1 registers all inputs; stage 2 registers the scaled colour and the selected outputs.
REQ-015 Latency input to output SHALL be exactly 2 cycles for colour, HS, VS and BLANK_N, with no bubbles.
REQ-016 Each background channel SHALL be computed as (c * fade_level) >> 4 using a 13-bit product, with bits [11:4] as the result.
REQ-017 At fade_level 16, the output SHALL equal c exactly; at fade_level 0, the output SHALL be 0.
REQ-018 When is_background=0, the output SHALL be fg_color unscaled.
REQ-019 When blank_n=0, the output SHALL be RGB 0, regardless of other inputs.
REQ-020 A step tick SHALL assert for 1 cycle on every FADE_STEP_FRAMES-th falling edge of vs_in (stage-1 copy).
REQ-021 FSM states SHALL be DARK, FADE_IN, SHOWN and FADE_OUT.
REQ-022 DARK: when status==BG_STATUS, go to FADE_IN; fade_level holds 0.
REQ-023 FADE_IN: on each tick, fade_level increments.
  - When fade_level reaches 16, go to SHOWN.
  - When status!=BG_STATUS, go to FADE_OUT from the current level (no jump).
REQ-024 SHOWN: when status!=BG_STATUS, go to FADE_OUT; fade_level holds 16.
REQ-025 FADE_OUT: on each tick, fade_level decrements.
  - When fade_level reaches 0, go to DARK.
  - When status==BG_STATUS, go to FADE_IN from the current level.
REQ-026 A status change and a tick in the same cycle: the transition SHALL take effect first, and the tick SHALL step in the new direction.
REQ-027 fade_level SHALL saturate at 0 and at 16 and never wrap.
REQ-028 The frame-step counter SHALL reset to 0 on every FSM state change.

Reset
REQ-029 Reset_n low SHALL asynchronously force the following:
  - FSM to DARK, fade_level 0, fade_busy 0, step counter 0;
  - all pipeline registers to 0, VGA_R/G/B 0;
  - VGA_HS, VGA_VS 1 (inactive), VGA_BLANK_N 0.
REQ-030 Reset mid-fade SHALL discard the fade; after release the block restarts from DARK.
REQ-031 Reset release SHALL be synchronous to Clk; valid outputs appear 2 cycles after the first valid input.

Configuration
REQ-032 Macro BG_FADE_EN: when defined, the FSM and scaling SHALL be built as specified.
REQ-033 Without BG_FADE_EN, the FSM and tick logic SHALL be omitted.
  - fade_level = 16 when status==BG_STATUS, else 0; fade_busy = 0.
  - Background pixels pass unscaled when status==BG_STATUS and are black otherwise.
  - The 2-cycle latency is unchanged.

Structure
REQ-034 Package bg_pkg SHALL hold the following:
  - fade_state_t enum (DARK, FADE_IN, SHOWN, FADE_OUT);
  - FADE_LEVEL_MAX=16 and the rgb24_t typedef.
REQ-035 Sub-module frame_strobe SHALL contain the vs falling-edge detector and the divide-by-FADE_STEP_FRAMES counter, and output a 1-cycle tick.

Verification
REQ-036 Reset, then status=BG_STATUS held with FADE_STEP_FRAMES=2 -> fade_level +1 every 2 frames; SHOWN after 32 frames; fade_busy falls in the same cycle.
REQ-037 bg_color=24'hF80504 at fade_level 8 -> RGB = 7C,02,02; at fade_level 16 -> F8,05,04.
REQ-038 Status leaves BG_STATUS at fade_level 10 -> FADE_OUT, level 9 at the next tick, DARK after 20 frames.
REQ-039 Toggle hs_in/vs_in/blank_n_in -> outputs mirror them exactly 2 cycles later; blank_n=0 forces RGB 000000.
REQ-040 Assert Reset_n low mid-FADE_IN without a clock edge -> outputs reset immediately; after release, state DARK and level 0.
REQ-041 Build without BG_FADE_EN, status=BG_STATUS -> bg_color passes unscaled after 2 cycles; fade_busy stays 0.
